// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions: opcodes, instruction formats and field positions,
// used by the instruction encoder and the control decoder.
package instr_encoder_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int unsigned OP_LSB    = 27;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS_LSB    = 17;
  localparam int unsigned RT_LSB    = 12;
  localparam int unsigned SHAMT_LSB = 7;
  localparam int unsigned ALUOP_LSB = 2;
  localparam int unsigned IMM_W     = 17;
  localparam int unsigned TGT_W     = 27;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_JI,
    FMT_JII,
    FMT_ILLEGAL
  } fmt_e;

  function automatic fmt_e decode_fmt(input logic [4:0] op);
    fmt_e f;
    case (op)
      OP_RTYPE:                               f = FMT_R;
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT:  f = FMT_I;
      OP_J, OP_JAL, OP_SETX, OP_BEX:          f = FMT_JI;
      OP_JR:                                  f = FMT_JII;
      default:                                f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction fields to a 32-bit word plus legal flag.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_shamt,
  input  logic [4:0]  i_aluop,
  input  logic [16:0] i_imm,
  input  logic [26:0] i_target,
  output logic [31:0] o_word,
  output logic        o_legal
);

  fmt_e w_fmt;

  assign w_fmt = decode_fmt(i_opcode);

  always_comb begin
    o_word  = '0;
    o_legal = 1'b1;
    case (w_fmt)
      FMT_R: begin
        o_word[OP_LSB +: 5]    = i_opcode;
        o_word[RD_LSB +: 5]    = i_rd;
        o_word[RS_LSB +: 5]    = i_rs;
        o_word[RT_LSB +: 5]    = i_rt;
        o_word[SHAMT_LSB +: 5] = i_shamt;
        o_word[ALUOP_LSB +: 5] = i_aluop;
      end
      FMT_I: begin
        o_word[OP_LSB +: 5]    = i_opcode;
        o_word[RD_LSB +: 5]    = i_rd;
        o_word[RS_LSB +: 5]    = i_rs;
        o_word[IMM_W-1:0]      = i_imm;
      end
      FMT_JI: begin
        o_word[OP_LSB +: 5]    = i_opcode;
        o_word[TGT_W-1:0]      = i_target;
      end
      FMT_JII: begin
        o_word[OP_LSB +: 5]    = i_opcode;
        o_word[RD_LSB +: 5]    = i_rd;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded fields, packs them and writes the word
// into instruction memory at an auto-incrementing, loadable pointer.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 4096,
  parameter int unsigned AW         = 12
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_opcode,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_shamt,
  input  logic [4:0]    in_aluop,
  input  logic [16:0]   in_imm,
  input  logic [26:0]   in_target,
  input  logic          load_addr,
  input  logic [AW-1:0] load_value,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_data,
  output logic          full,
  output logic          err_illegal,
  output logic [AW:0]   count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);
  localparam logic [AW:0]   MAX_COUNT = (AW+1)'(IMEM_DEPTH);

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;
  logic          r_we;
  logic          r_err;
  logic [AW:0]   r_count;

  logic [31:0]   w_word;
  logic          w_legal;
  logic          w_xfer;

  instr_pack u_pack (
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rs     (in_rs),
    .i_rt     (in_rt),
    .i_shamt  (in_shamt),
    .i_aluop  (in_aluop),
    .i_imm    (in_imm),
    .i_target (in_target),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  assign in_ready = reset_n && (r_state == S_IDLE) && !load_addr;
  assign w_xfer   = in_valid && in_ready;

  // Gating with reset_n drops a pending write in the cycle reset is applied.
  assign imem_we     = r_we && reset_n;
  assign imem_addr   = r_addr;
  assign imem_data   = r_data;
  assign full        = (r_state == S_FULL);
  assign err_illegal = r_err;
  assign count       = r_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_addr) begin
            r_ptr <= load_value;
          end else if (w_xfer) begin
            if (w_legal) begin
              r_we    <= 1'b1;
              r_addr  <= r_ptr;
              r_data  <= w_word;
              r_state <= S_WRITE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        // Pointer and count advance once the write cycle has completed.
        S_WRITE: begin
          r_ptr <= r_ptr + AW'(1);
          if (r_count != MAX_COUNT) r_count <= r_count + (AW+1)'(1);
          r_state <= (r_addr == LAST_ADDR) ? S_FULL : S_IDLE;
        end
        S_FULL: begin
          if (load_addr) begin
            r_ptr   <= load_value;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
